fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Sequences the PC register and the instruction-memory fetch port for the RV32 core's IF stage.
- Decides the next PC each cycle: reset vector, trap vector, branch/jump redirect, or sequential +4.
- Drives the PC register's write enable and data input, and issues one outstanding imem request at a time.
- Presents fetched instructions to decode through a 1-entry valid/ready buffer and kills stale responses after a redirect.

Parameters:
RESET_VEC, 32'h0000_0000, PC loaded on the first cycle after reset deassertion
NOP_INSTR, 32'h0000_0013, instruction word driven on a fetch fault (addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
pc_q  in  32  current PC from the PC register
pc_wen  out  1  PC register write enable
pc_din  out  32  next PC value
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, always equal to pc_q
imem_gnt  in  1  request accepted; memory samples imem_addr only when imem_req && imem_gnt
imem_rvalid  in  1  response valid, at least 1 cycle after gnt
imem_rdata  in  32  response instruction
trap_valid  in  1  trap/exception redirect
trap_vec  in  32  trap target
redir_valid  in  1  branch/jump redirect from EX
redir_target  in  32  branch/jump target
if_valid  out  1  instruction buffer full
if_ready  in  1  decode accepts the buffer entry
if_pc  out  32  PC of the buffered instruction
if_instr  out  32  buffered instruction
if_fault  out  1  buffered entry is a misaligned-fetch fault

Behaviour:
- Reset (async, any state): state=BOOT, kill=0, if_valid=0, if_pc=0, if_instr=0, if_fault=0.
- While rst is high: imem_req=0, pc_wen=0, pc_din=0.
- States:
  - BOOT: one cycle; pc_wen=1, pc_din=RESET_VEC -> REQ.
  - REQ:
    - imem_req=1 only when (!if_valid || if_ready) and pc_q[1:0]==0.
    - Request and gnt -> WAIT.
    - pc_q[1:0]!=0 and buffer free -> load buffer {if_pc=pc_q, if_instr=NOP_INSTR, if_fault=1}, no request -> FAULT.
  - WAIT: imem_req=0.
    - rvalid with kill=0: load buffer {pc_q, imem_rdata, fault=0}, pc_wen=1, pc_din=pc_q+4 (mod 2^32) -> REQ.
    - rvalid with kill=1: discard the response, clear kill, no PC write -> REQ.
  - FAULT: imem_req=0; holds until trap or redirect.
- Buffer: if_valid&&if_ready clears the entry at the edge. A request issues only when the buffer is empty after that edge, so a non-killed response always finds the buffer empty.
- Redirect (any state except BOOT), priority trap > redir > sequential:
  - pc_wen=1, pc_din=trap_vec or redir_target in the same cycle.
  - if_valid cleared at the next edge.
  - State -> REQ, unless this is a WAIT cycle with no rvalid, which stays in WAIT with kill=1.
  - REQ cycle with a gnt -> WAIT with kill=1.
  - WAIT cycle with rvalid -> response dropped, -> REQ.
  - Sequential +4 is suppressed in the redirect cycle.
- A redirect while kill=1 keeps kill=1, so only one stale response is dropped.
- No imem_req stability rule: the address may change between ungranted request cycles.
- imem_rvalid outside WAIT is ignored. if_ready with if_valid=0 is ignored.
- Latency: minimum 2 cycles from request issue to if_valid (gnt cycle plus 1-cycle response).

Decomposition:
- fetch_pkg: state enum {BOOT, REQ, WAIT, FAULT}, PC_STEP=32'd4, NOP constant.
- No sub-module; the buffer and FSM live in fetch_ctrl.

Test Plan:
- Reset release, RESET_VEC=32'h80, zero-wait memory (gnt every cycle, rvalid next) -> pc_din=32'h80 in BOOT; if_pc 0x80, 0x84, 0x88 with if_ready=1; steady throughput one instruction per 2 cycles.
- if_ready=0 for 5 cycles with one entry buffered -> imem_req stays 0 and pc_q holds. Raising if_ready -> request issues in the same cycle.
- redir_valid, target 32'h200, in WAIT with rvalid 3 cycles later -> pc_din=0x200 that cycle, if_valid=0 next, stale response dropped, next if_pc=0x200.
- trap_valid (0x100) and redir_valid (0x300) in the same cycle -> pc_din=0x100.
- redir_target=32'h202 -> fault entry {if_pc=0x202, if_instr=32'h13, if_fault=1}, no imem_req until trap_valid, then fetch from trap_vec.
- Sequential at pc_q=32'hFFFF_FFFC -> pc_din=0. Async rst asserted mid-WAIT -> all outputs 0 immediately, pending rvalid ignored after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage fetch controller.
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      REQ   = 2'd1,
      WAIT  = 2'd2,
      FAULT = 2'd3
   } fetch_state_e;

   localparam logic [31:0] PC_STEP  = 32'd4;
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory port plus the fetch-to-decode buffer handshake.
interface fetch_ctrl_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_fault;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      output if_valid, if_pc, if_instr, if_fault,
      input  if_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      input  if_valid, if_pc, if_instr, if_fault,
      output if_ready
   );

endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: next-PC selection, single outstanding imem fetch,
// and a one-entry instruction buffer towards decode.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_q,
   output logic        pc_wen,
   output logic [31:0] pc_din,
   input  logic        trap_valid,
   input  logic [31:0] trap_vec,
   input  logic        redir_valid,
   input  logic [31:0] redir_target,
   fetch_ctrl_if.master bus
);

   fetch_state_e state_q, state_d;
   logic         kill_q, kill_d;

   logic        buf_v_q;
   logic [31:0] buf_pc_q;
   logic [31:0] buf_instr_q;
   logic        buf_fault_q;

   logic        req;
   logic        wen;
   logic [31:0] din;
   logic        ld;
   logic [31:0] ld_instr;
   logic        ld_fault;
   logic        buf_free;
   logic        aligned;
   logic        redirect;
   logic [31:0] redir_pc;

   assign buf_free = !buf_v_q || bus.if_ready;
   assign aligned  = (pc_q[1:0] == 2'b00);
   assign redirect = (state_q != BOOT) && (trap_valid || redir_valid);
   assign redir_pc = trap_valid ? trap_vec : redir_target;

   always_comb begin
      state_d  = state_q;
      kill_d   = kill_q;
      req      = 1'b0;
      wen      = 1'b0;
      din      = 32'd0;
      ld       = 1'b0;
      ld_instr = NOP_INSTR;
      ld_fault = 1'b0;

      unique case (state_q)
         BOOT: begin
            wen     = 1'b1;
            din     = RESET_VEC;
            state_d = REQ;
         end
         REQ: begin
            req = buf_free && aligned;
            if (req && bus.imem_gnt) begin
               state_d = WAIT;
            end else if (!aligned && buf_free) begin
               ld       = 1'b1;
               ld_fault = 1'b1;
               state_d  = FAULT;
            end
         end
         WAIT: begin
            if (bus.imem_rvalid) begin
               state_d = REQ;
               if (kill_q) begin
                  kill_d = 1'b0;
               end else begin
                  ld       = 1'b1;
                  ld_instr = bus.imem_rdata;
                  wen      = 1'b1;
                  din      = pc_q + PC_STEP;
               end
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: state_d = BOOT;
      endcase

      // A redirect overrides the sequential path; an in-flight fetch is
      // remembered in kill so its response gets dropped.
      if (redirect) begin
         wen = 1'b1;
         din = redir_pc;
         ld  = 1'b0;
         if ((state_q == WAIT && !bus.imem_rvalid) ||
             (state_q == REQ && req && bus.imem_gnt)) begin
            state_d = WAIT;
            kill_d  = 1'b1;
         end else begin
            state_d = REQ;
            kill_d  = 1'b0;
         end
      end

      if (rst) begin
         req = 1'b0;
         wen = 1'b0;
         din = 32'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BOOT;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         kill_q  <= kill_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_v_q     <= 1'b0;
         buf_pc_q    <= 32'd0;
         buf_instr_q <= 32'd0;
         buf_fault_q <= 1'b0;
      end else if (redirect) begin
         buf_v_q <= 1'b0;
      end else if (ld) begin
         buf_v_q     <= 1'b1;
         buf_pc_q    <= pc_q;
         buf_instr_q <= ld_instr;
         buf_fault_q <= ld_fault;
      end else if (buf_v_q && bus.if_ready) begin
         buf_v_q <= 1'b0;
      end
   end

   assign pc_wen        = wen;
   assign pc_din        = din;
   assign bus.imem_req  = req;
   assign bus.imem_addr = pc_q;
   assign bus.if_valid  = buf_v_q;
   assign bus.if_pc     = buf_pc_q;
   assign bus.if_instr  = buf_instr_q;
   assign bus.if_fault  = buf_fault_q;

endmodule
